// File: rtl/bomber_pkg.sv
// Shared command codes, FSM encodings and key indices for the keypad scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bomber_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_UP     = 3'd1,
    CMD_DOWN   = 3'd2,
    CMD_LEFT   = 3'd3,
    CMD_RIGHT  = 3'd4,
    CMD_ACTION = 3'd5
  } cmd_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } sched_state_e;

  // Key index order matches cmd_code minus one, so a grant index maps
  // straight onto its command code.
  localparam int NUM_KEYS   = 5;
  localparam int KEY_UP     = 0;
  localparam int KEY_DOWN   = 1;
  localparam int KEY_LEFT   = 2;
  localparam int KEY_RIGHT  = 3;
  localparam int KEY_ACTION = 4;

  function automatic cmd_code_e key_to_code(input logic [2:0] key_idx);
    return cmd_code_e'(key_idx + 3'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: debounced level flips after DEB_CYCLES consecutive differing samples.
// Latency: DEB_CYCLES cycles from a stable raw change to deb; rise is a 1-cycle pulse with deb's first high cycle.
// Backpressure: none (free-running).
// Ports: clk, rst (sync, active-high), raw (scanner level), deb (debounced level), rise (debounced 0->1 pulse).
module key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      deb  <= 1'b0;
      rise <= 1'b0;
      cnt  <= '0;
    end else begin
      rise <= 1'b0;
      if (raw != deb) begin
        // cnt holds the number of earlier differing cycles, so this is the last one
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          deb  <= raw;
          rise <= raw;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/keypad_cmd_scheduler.sv
// Keypad command scheduler: debounce, auto-repeat, per-key pending bits, action-first/round-robin arbitration.
// Latency: pending set 1 cycle after debounced rise; cmd_valid 1 cycle after a pending bit is seen in IDLE.
// Backpressure: offered command held stable until cmd_ready; one command per 2 cycles at most.
// Ports: clk, rst (sync, active-high), up/down/left/right/action (raw levels),
//        cmd_ready (sink accepts), cmd_valid/cmd_code (offered command).
module keypad_cmd_scheduler
  import bomber_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_DELAY  = 256,
  parameter int REPEAT_PERIOD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       action,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code
);

  localparam int HW = $clog2(REPEAT_DELAY) + 1;

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] evt;
  logic [NUM_KEYS-1:0] set_mask;
  logic [NUM_KEYS-1:0] clr_mask;
  logic [NUM_KEYS-1:0] pend;
  logic [3:0]          rep_evt;
  logic [HW-1:0]       hold_cnt [4];

  sched_state_e state, state_nxt;
  cmd_code_e    code_q, code_nxt;
  logic [1:0]   rr_ptr, rr_nxt;
  logic [2:0]   win_idx;
  logic [2:0]   grant_idx;
  logic [1:0]   cand;

  assign raw_keys[KEY_UP]     = up;
  assign raw_keys[KEY_DOWN]   = down;
  assign raw_keys[KEY_LEFT]   = left;
  assign raw_keys[KEY_RIGHT]  = right;
  assign raw_keys[KEY_ACTION] = action;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_keys[g]),
      .deb  (deb[g]),
      .rise (rise[g])
    );
  end

  // Hold counters (directions only). After the first repeat the counter is
  // reloaded so it reaches REPEAT_DELAY again exactly REPEAT_PERIOD cycles later.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rep_evt[i] = deb[i] && (hold_cnt[i] == HW'(REPEAT_DELAY));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || !deb[i]) begin
        hold_cnt[i] <= '0;
      end else if (rep_evt[i]) begin
        hold_cnt[i] <= HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      end else begin
        hold_cnt[i] <= hold_cnt[i] + HW'(1);
      end
    end
  end

  // New requests; opposing directions held together suppress new sets only.
  always_comb begin
    evt      = (rise & deb) | {1'b0, rep_evt};
    set_mask = evt;
    if (deb[KEY_UP] && deb[KEY_DOWN]) begin
      set_mask[KEY_UP]   = 1'b0;
      set_mask[KEY_DOWN] = 1'b0;
    end
    if (deb[KEY_LEFT] && deb[KEY_RIGHT]) begin
      set_mask[KEY_LEFT]  = 1'b0;
      set_mask[KEY_RIGHT] = 1'b0;
    end
  end

  // Action wins outright; otherwise first pending direction at or after rr_ptr.
  // Scanning from the farthest offset down lets the nearest one overwrite.
  always_comb begin
    win_idx = 3'(KEY_ACTION);
    cand    = '0;
    if (!pend[KEY_ACTION]) begin
      for (int j = 3; j >= 0; j--) begin
        cand = rr_ptr + 2'(j);
        if (pend[cand]) begin
          win_idx = {1'b0, cand};
        end
      end
    end
  end

  assign grant_idx = code_q - 3'd1;

  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    rr_nxt    = rr_ptr;
    clr_mask  = '0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          code_nxt  = key_to_code(win_idx);
          state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (cmd_ready) begin
          clr_mask[grant_idx] = 1'b1;
          if (code_q != CMD_ACTION) begin
            rr_nxt = grant_idx[1:0] + 2'd1;
          end
          code_nxt  = CMD_NONE;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        code_nxt  = CMD_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      code_q <= CMD_NONE;
      rr_ptr <= 2'd0;
      pend   <= '0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      rr_ptr <= rr_nxt;
      // A set in the same cycle as the transfer-clear keeps the bit.
      pend   <= (pend & ~clr_mask) | set_mask;
    end
  end

  assign cmd_valid = (state == ST_OFFER);
  assign cmd_code  = code_q;

endmodule

// File: tb/tb_keypad_cmd_scheduler.sv
module tb_keypad_cmd_scheduler;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right, action;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;

  logic [4:0] keys;
  int n_tests = 0;
  int n_fail  = 0;
  int got_codes[$];

  // Reference model state: debounced level, differing-run length, age since
  // debounced rise, pending flags, offered key (-1 = none), next rr direction.
  int m_db[5];
  int m_run[5];
  int m_age[5];
  int m_pend[5];
  int m_cur = -1;
  int m_rr = 0;

  always #5 clk = ~clk;

  keypad_cmd_scheduler #(
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .action(action), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void model_step();
    int ev[5];
    int found;
    int idx;
    int flipped;
    if (rst) begin
      for (int k = 0; k < 5; k++) begin
        m_db[k] = 0; m_run[k] = 0; m_age[k] = 0; m_pend[k] = 0;
      end
      m_cur = -1;
      m_rr  = 0;
      return;
    end
    for (int k = 0; k < 5; k++) begin
      ev[k] = (m_db[k] != 0 && (m_age[k] == 0 ||
               (k < 4 && m_age[k] >= RD && ((m_age[k] - RD) % RP) == 0))) ? 1 : 0;
    end
    if (m_db[0] != 0 && m_db[1] != 0) begin ev[0] = 0; ev[1] = 0; end
    if (m_db[2] != 0 && m_db[3] != 0) begin ev[2] = 0; ev[3] = 0; end
    if (m_cur < 0) begin
      if (m_pend[4] != 0) m_cur = 4;
      else begin
        found = 0;
        for (int j = 0; j < 4; j++) begin
          idx = (m_rr + j) % 4;
          if (found == 0 && m_pend[idx] != 0) begin
            m_cur = idx;
            found = 1;
          end
        end
      end
    end else if (cmd_ready) begin
      m_pend[m_cur] = 0;
      if (m_cur < 4) m_rr = (m_cur + 1) % 4;
      m_cur = -1;
    end
    for (int k = 0; k < 5; k++) if (ev[k] != 0) m_pend[k] = 1;
    for (int k = 0; k < 5; k++) begin
      flipped = 0;
      if (int'(keys[k]) != m_db[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_db[k]  = int'(keys[k]);
          m_run[k] = 0;
          flipped  = 1;
        end
      end else begin
        m_run[k] = 0;
      end
      if (flipped != 0) m_age[k] = 0;
      else if (m_db[k] != 0) m_age[k]++;
    end
  endfunction

  task automatic tick();
    up = keys[0]; down = keys[1]; left = keys[2]; right = keys[3]; action = keys[4];
    if (!rst && cmd_valid && cmd_ready) got_codes.push_back(int'(cmd_code));
    @(posedge clk);
    model_step();
    #1;
    chk("model_valid", int'(cmd_valid), (m_cur >= 0) ? 1 : 0);
    chk("model_code", int'(cmd_code), (m_cur >= 0) ? m_cur + 1 : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int count_code(input int code);
    int c = 0;
    foreach (got_codes[i]) if (got_codes[i] == code) c++;
    return c;
  endfunction

  function automatic int code_at(input int i);
    return (got_codes.size() > i) ? got_codes[i] : -1;
  endfunction

  initial begin
    rst = 1'b1; keys = 5'b0; cmd_ready = 1'b1;
    run(3);
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_code", int'(cmd_code), 0);
    rst = 1'b0;
    run(5);

    // Short glitch is rejected; a 6-cycle press gives one up command.
    got_codes.delete();
    keys = 5'b00001; run(3);
    keys = 5'b00000; run(20);
    chk("short_press_cnt", got_codes.size(), 0);
    keys = 5'b00001; run(6);
    keys = 5'b00000; run(20);
    chk("press_up_cnt", got_codes.size(), 1);
    chk("press_up_code", code_at(0), 1);

    // Auto-repeat on right; action never repeats.
    got_codes.delete();
    keys = 5'b01000; run(60);
    keys = 5'b00000; run(20);
    chk("repeat_right_cnt", got_codes.size(), 5);
    chk("repeat_right_code4", count_code(4), 5);
    got_codes.delete();
    keys = 5'b10000; run(60);
    keys = 5'b00000; run(20);
    chk("action_hold_cnt", got_codes.size(), 1);
    chk("action_hold_code", code_at(0), 5);

    // Simultaneous up, left, action: action first, then round-robin from up.
    got_codes.delete();
    keys = 5'b10101; run(8);
    keys = 5'b00000; run(20);
    chk("arb_cnt", got_codes.size(), 3);
    chk("arb_first", code_at(0), 5);
    chk("arb_second", code_at(1), 1);
    chk("arb_third", code_at(2), 3);

    // Backpressure: offer held while the key is released.
    got_codes.delete();
    cmd_ready = 1'b0;
    keys = 5'b00010; run(6);
    keys = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", int'(cmd_valid), 1);
      chk("hold_code", int'(cmd_code), 2);
    end
    cmd_ready = 1'b1; tick();
    chk("after_xfer_valid", int'(cmd_valid), 0);
    chk("after_xfer_code", int'(cmd_code), 0);
    run(10);
    chk("xfer_cnt", got_codes.size(), 1);
    chk("xfer_code", code_at(0), 2);

    // Up and down together are suppressed; left still gets through.
    got_codes.delete();
    keys = 5'b00011; run(20);
    keys = 5'b00111; run(6);
    keys = 5'b00011; run(34);
    keys = 5'b00000; run(20);
    chk("conflict_updown", count_code(1) + count_code(2), 0);
    chk("conflict_left", count_code(3), 1);

    // Reset during an offer discards it; held key re-fires afterwards.
    got_codes.delete();
    cmd_ready = 1'b0;
    keys = 5'b00010; run(6);
    chk("pre_rst_valid", int'(cmd_valid), 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("post_rst_valid", int'(cmd_valid), 0);
    chk("post_rst_code", int'(cmd_code), 0);
    cmd_ready = 1'b1;
    run(3);
    chk("rst_no_deliver", got_codes.size(), 0);
    run(9);
    chk("rst_refire_cnt", got_codes.size(), 1);
    chk("rst_refire_code", code_at(0), 2);
    keys = 5'b00000; run(20);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 15) == 0) keys[k] = ~keys[k];
      end
      cmd_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; keys = 5'b0; cmd_ready = 1'b1;
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_cmd_scheduler.md
KEYPAD_CMD_SCHEDULER -- requirements
Module: keypad_cmd_scheduler

Interface
REQ-001 Parameter DEB_CYCLES, 16, consecutive clk cycles a raw key level must differ from its debounced state before the debounced state flips.
REQ-002 Parameter REPEAT_DELAY, 256, cycles a direction key is held debounced-high before its first auto-repeat request.
REQ-003 Parameter REPEAT_PERIOD, 64, cycles between subsequent auto-repeat requests while the key stays held.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 up, down, left, right, action  input  1 each  raw key levels from the keypad scanner; 1 = pressed.
REQ-007 cmd_ready  input  1  game logic accepts the offered command.
REQ-008 cmd_valid  output  1  command offered.
REQ-009 cmd_code  output  3  command: 0 none, 1 up, 2 down, 3 left, 4 right, 5 action.

Function
REQ-010 Per key debounce: a counter runs while raw != debounced and clears when raw == debounced; when it reaches DEB_CYCLES the debounced state flips and the counter clears.
REQ-011 A debounced 0->1 transition of any key sets that key's pending bit on the following cycle.
REQ-012 Direction keys only: a hold counter starts at the debounced rise; at REPEAT_DELAY cycles it sets pending, then every REPEAT_PERIOD cycles; the counter clears on the debounced fall.
REQ-013 action never auto-repeats; one command per debounced press.
REQ-014 Conflict: while up and down are both debounced-high, no new pending sets occur for up or down; left/right likewise; bits already pending remain pending.
REQ-015 A set on an already-pending bit coalesces; there is no queue depth beyond one per key.
REQ-016 FSM states: IDLE and OFFER.
REQ-017 IDLE: if any pending bit is set, latch the winner into cmd_code and go to OFFER; cmd_valid is 1 from the next cycle.
REQ-018 Arbitration: action has absolute priority; directions are round-robin in the order up, down, left, right, starting after the last granted direction.
REQ-019 OFFER: cmd_valid=1 and cmd_code is held stable until cmd_ready=1; that cycle is the transfer.
REQ-020 On transfer: clear the granted pending bit, advance the round-robin pointer if the grant was a direction, return to IDLE; cmd_valid=0 and cmd_code=0 the next cycle. Maximum throughput is one command per 2 cycles.
REQ-021 A pending set and a transfer-clear of the same key in the same cycle leave the bit set.
REQ-022 Releasing a key during OFFER does not withdraw the offered command.
REQ-023 cmd_ready while in IDLE is ignored.

Reset
REQ-024 rst=1 at posedge clk forces: state IDLE, cmd_valid 0, cmd_code 0, all pending bits 0, all debounced states 0, all debounce and hold counters 0, round-robin pointer to up.
REQ-025 Reset during OFFER discards the offered command; no transfer is reported.
REQ-026 Keys held across reset release are treated as new presses after DEB_CYCLES.

Structure
REQ-027 The cmd_code values and FSM state encodings are defined in the shared package bomber_pkg.
REQ-028 A sub-module key_debounce (raw in, debounced out, rise pulse out, parameter DEB_CYCLES) is instantiated once per key (5 instances).
REQ-029 Counter widths are derived with $clog2 of the parameters plus 1.

Verification (bench overrides: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=10; cmd_ready tied 1 unless stated)
REQ-030 Press up for 3 cycles, then release -> no cmd_valid ever; press up for 6 cycles -> exactly one command, cmd_code=1.
REQ-031 Hold right for 60 cycles -> commands with code 4: one at the press, then at hold counts 20, 30, 40, 50 (5 total); hold action for 60 cycles -> exactly one command, code 5.
REQ-032 Debounced up, left and action all rise in the same cycle, then all release -> commands in order 5, 1, 3.
REQ-033 With cmd_ready=0, press down -> cmd_valid=1 and code 2 held for 10 cycles while down is released; raise cmd_ready -> one transfer, then cmd_valid=0.
REQ-034 Hold up and down together for 60 cycles -> no further up/down commands after the debounced overlap begins; left pressed meanwhile -> code 3 delivered.
REQ-035 Assert rst during OFFER -> cmd_valid=0 the next cycle, pending bits cleared, no command delivered; a still-held key yields a new command after 4 cycles.
